timer_alarm_scheduler: RTL

TIMER_ALARM_SCHEDULER -- requirements
Module: timer_alarm_scheduler

---
 rtl/timer_sched_pkg.sv | 20 ++
 rtl/alarm_channel.sv | 85 ++++++++
 rtl/timer_alarm_scheduler.sv | 88 ++++++++
 3 files changed

// File: rtl/timer_sched_pkg.sv
// Shared constants and types for the timer alarm scheduler:
// register addresses, CTRL field positions and the channel state type.
package timer_sched_pkg;

  localparam int MAX_ALARMS = 4;

  localparam logic [3:0] ADDR_COMPARE0 = 4'd0;
  localparam logic [3:0] ADDR_PERIOD0  = 4'd4;
  localparam logic [3:0] ADDR_CTRL     = 4'd8;
  localparam logic [3:0] ADDR_PENDING  = 4'd9;

  localparam int CTRL_ENABLE_LSB   = 0;
  localparam int CTRL_PERIODIC_LSB = 4;

  typedef enum logic {
    CH_IDLE  = 1'b0,
    CH_ARMED = 1'b1
  } ch_state_e;

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: COMPARE/PERIOD registers and the IDLE/ARMED state machine.
// PERIOD, PERIODIC and the periodic reload exist only with ALARM_PERIODIC_EN.
//
//   state    | meaning
//   CH_IDLE  | ENABLE=0, ticks are ignored
//   CH_ARMED | ENABLE=1, fires on ms_tick when ms_count equals COMPARE
module alarm_channel
  import timer_sched_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ms_tick,
  input  logic [31:0] ms_count,
  input  logic [31:0] wdata,
  input  logic        compare_we,
  input  logic        period_we,
  input  logic        ctrl_we,
  input  logic        ctrl_enable,
  input  logic        ctrl_periodic,
  output logic [31:0] compare,
  output logic [31:0] period,
  output logic        enable,
  output logic        periodic,
  output logic        match
);

  ch_state_e   state_q, state_d;
  logic [31:0] compare_q, compare_d;
  logic        reload;

`ifdef ALARM_PERIODIC_EN
  logic [31:0] period_q;
  logic        periodic_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      period_q   <= '0;
      periodic_q <= 1'b0;
    end else begin
      if (period_we) period_q <= wdata;
      if (ctrl_we)   periodic_q <= ctrl_periodic;
    end
  end

  // A zero period would re-fire at the same count forever, so it acts as one-shot.
  assign reload   = periodic_q && (period_q != '0);
  assign period   = period_q;
  assign periodic = periodic_q;
`else
  logic unused_cfg;
  assign unused_cfg = period_we ^ ctrl_periodic;
  assign reload     = 1'b0;
  assign period     = '0;
  assign periodic   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    compare_d = compare_q;
    // Register writes to this channel win over a coincident match.
    match     = (state_q == CH_ARMED) && ms_tick && (ms_count == compare_q)
                && !compare_we && !ctrl_we;
    if (ctrl_we) begin
      state_d = ctrl_enable ? CH_ARMED : CH_IDLE;
    end else if (match) begin
      if (reload) compare_d = compare_q + period;
      else        state_d   = CH_IDLE;
    end
    if (compare_we) compare_d = wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CH_IDLE;
      compare_q <= '0;
    end else begin
      state_q   <= state_d;
      compare_q <= compare_d;
    end
  end

  assign compare = compare_q;
  assign enable  = (state_q == CH_ARMED);

endmodule

// File: rtl/timer_alarm_scheduler.sv
// Timer alarm scheduler top: register decode, PENDING, rdata and interupt around
// NUM_ALARMS alarm_channel instances. Periodic alarms need ALARM_PERIODIC_EN.
module timer_alarm_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_ALARMS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ms_tick,
  input  logic [31:0] ms_count,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] rdata,
  output logic        interupt
);

  logic [MAX_ALARMS-1:0] match_v;
  logic [MAX_ALARMS-1:0] enable_v;
  logic [MAX_ALARMS-1:0] periodic_v;
  logic [31:0]           compare_v [MAX_ALARMS];
  logic [31:0]           period_v  [MAX_ALARMS];
  logic                  ctrl_we;
  logic [MAX_ALARMS-1:0] pending_q;
  logic [MAX_ALARMS-1:0] pending_clr;
  logic [31:0]           rd_mux;

  assign ctrl_we     = write && (addr == ADDR_CTRL);
  assign pending_clr = (write && (addr == ADDR_PENDING)) ? wdata[MAX_ALARMS-1:0] : '0;

  for (genvar g = 0; g < MAX_ALARMS; g++) begin : g_ch
    if (g < NUM_ALARMS) begin : g_on
      alarm_channel u_ch (
        .clock         (clock),
        .reset         (reset),
        .ms_tick       (ms_tick),
        .ms_count      (ms_count),
        .wdata         (wdata),
        .compare_we    (write && (addr == ADDR_COMPARE0 + 4'(g))),
        .period_we     (write && (addr == ADDR_PERIOD0 + 4'(g))),
        .ctrl_we       (ctrl_we),
        .ctrl_enable   (wdata[CTRL_ENABLE_LSB + g]),
        .ctrl_periodic (wdata[CTRL_PERIODIC_LSB + g]),
        .compare       (compare_v[g]),
        .period        (period_v[g]),
        .enable        (enable_v[g]),
        .periodic      (periodic_v[g]),
        .match         (match_v[g])
      );
    end else begin : g_off
      assign compare_v[g]  = '0;
      assign period_v[g]   = '0;
      assign enable_v[g]   = 1'b0;
      assign periodic_v[g] = 1'b0;
      assign match_v[g]    = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (addr < ADDR_PERIOD0) begin
      rd_mux = compare_v[addr[1:0]];
    end else if (addr < ADDR_CTRL) begin
      rd_mux = period_v[addr[1:0]];
    end else if (addr == ADDR_CTRL) begin
      rd_mux[CTRL_ENABLE_LSB +: MAX_ALARMS]   = enable_v;
      rd_mux[CTRL_PERIODIC_LSB +: MAX_ALARMS] = periodic_v;
    end else if (addr == ADDR_PENDING) begin
      rd_mux[MAX_ALARMS-1:0] = pending_q;
    end
  end

  // A new match on a bit beats a simultaneous write-1-to-clear of that bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
      interupt  <= 1'b0;
      rdata     <= '0;
    end else begin
      pending_q <= (pending_q & ~pending_clr) | match_v;
      interupt  <= |pending_q;
      if (read) rdata <= rd_mux;
    end
  end

endmodule
